// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default rates and line levels.
package uart_pkg;

  localparam int unsigned DEFAULT_CLOCK_FREQ = 125_000_000;
  localparam int unsigned DEFAULT_BAUD_RATE  = 115_200;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the TX FIFO (slave) and the UART drain stage (master).
interface fifo_uart_tx_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en
  );

endinterface

// File: rtl/fifo_uart_tx_baud_counter.sv
// Bit-period counter: emits a one-cycle tick on the last cycle of every serial bit.
module baud_counter #(
  parameter int unsigned SYMBOL_EDGE_TIME = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned CLOCK_COUNTER_WIDTH =
      (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

  logic [CLOCK_COUNTER_WIDTH-1:0] count_q, count_d;

  assign tick_o = enable_i && (count_q == CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_o) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the TX FIFO and serializes each byte as a UART frame (8N1, or 8E1 when
// FIFO_UART_TX_PARITY_EN is defined).
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
  parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_uart_tx_if.master        fifo,
  output logic                  serial_out,
  output logic                  busy
);

  localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned BitCntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic               serial_q, serial_d;
  logic               baud_tick, baud_clear, baud_en;
`ifdef FIFO_UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  // Counter idles at zero until the frame starts, so each bit state begins at count 0.
  assign baud_clear = (state_q == IDLE) || (state_q == LOAD);
  assign baud_en    = !baud_clear;

  baud_counter #(
    .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
  ) u_baud_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (baud_clear),
    .enable_i(baud_en),
    .tick_o  (baud_tick)
  );

  // Gated by rst so no pop can be committed while the block is held in reset.
  assign fifo.fifo_rd_en = rst && (state_q == IDLE) && !fifo.fifo_empty;
  assign busy            = (state_q != IDLE);
  assign serial_out      = serial_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    serial_d  = serial_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        serial_d = STOP_BIT;
        if (!fifo.fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        shift_d   = fifo.fifo_dout;
        bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = ^fifo.fifo_dout;
`endif
        serial_d  = START_BIT;
        state_d   = START;
      end
      START: begin
        if (baud_tick) begin
          serial_d = shift_q[0];
          state_d  = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == BitCntW'(WIDTH - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
            serial_d = parity_q;
            state_d  = PARITY;
`else
            serial_d = STOP_BIT;
            state_d  = STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            serial_d  = shift_d[0];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          serial_d = STOP_BIT;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          serial_d = STOP_BIT;
          state_d  = IDLE;
        end
      end
      default: begin
        serial_d = STOP_BIT;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= STOP_BIT;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds bytes, a line monitor decodes frames.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int unsigned ClkFreq = 1000;
  localparam int unsigned Baud    = 100;
  localparam int unsigned Width   = 8;
  localparam int unsigned SymT    = ClkFreq / Baud;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int unsigned FrameBits = Width + 3;
`else
  localparam int unsigned FrameBits = Width + 2;
`endif
  localparam int unsigned FrameCycles = FrameBits * SymT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic serial_out;
  logic busy;

  fifo_uart_tx_if #(.WIDTH(Width)) ifc ();

  fifo_uart_tx #(
    .CLOCK_FREQ(ClkFreq),
    .BAUD_RATE (Baud),
    .WIDTH     (Width)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo      (ifc.master),
    .serial_out(serial_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle registered read latency.
  logic [7:0] mem [256];
  int pushed_n = 0;
  int popped_n = 0;

  always_comb ifc.fifo_empty = (pushed_n == popped_n);

  always @(posedge clk) begin
    if (ifc.fifo_rd_en) begin
      ifc.fifo_dout <= mem[popped_n[7:0]];
      popped_n      <= popped_n + 1;
    end
  end

  int rd_pulses = 0;
  int busy_cycles = 0;
  int rd_while_empty = 0;

  always @(negedge clk) begin
    if (ifc.fifo_rd_en) rd_pulses <= rd_pulses + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
    if (ifc.fifo_rd_en && ifc.fifo_empty) rd_while_empty <= rd_while_empty + 1;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard
  logic [7:0] exp_q[$];
  logic mon_en = 1'b1;
  int frames_done = 0;
  int gap_cnt = 0;
  int last_gap = -1;

  initial begin : monitor
    logic [7:0]  b;
    logic [15:0] eb;
    int          bad;
    logic        got;
    forever begin
      @(negedge clk);
      if (rst && mon_en && serial_out === 1'b0) begin
        last_gap = gap_cnt;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame: start bit seen, no byte expected");
        end else begin
          b = exp_q.pop_front();
          eb = '1;
          eb[0] = 1'b0;
          for (int i = 0; i < Width; i++) eb[1+i] = b[i];
`ifdef FIFO_UART_TX_PARITY_EN
          eb[Width+1] = ^b;
`endif
          bad = -1;
          got = 1'b0;
          for (int k = 0; k < FrameCycles; k++) begin
            if (k > 0) @(negedge clk);
            if (bad < 0 && serial_out !== eb[k/SymT]) begin
              bad = k;
              got = serial_out;
            end
          end
          n_tests++;
          if (bad >= 0) begin
            n_fail++;
            $display("FAIL frame_%02h: cycle %0d line %b, expected %b", b, bad, got,
                     eb[bad/SymT]);
          end
        end
        frames_done++;
        gap_cnt = 0;
      end else if (serial_out === 1'b1) begin
        gap_cnt++;
      end
    end
  end

  task automatic wait_frames(input int target, input string name);
    int n;
    n = 0;
    while (frames_done < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, frames_done, target);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat;
    int rd0;
    int busy0;
    int lows;

    // Reset held with a byte waiting: nothing may move.
    mem[0] = 8'hA5;
    pushed_n = 1;
    exp_q.push_back(8'hA5);
    repeat (5) begin
      @(negedge clk);
      #1;
      check("rst_serial", serial_out, 1);
      check("rst_busy", busy, 0);
      check("rst_rd_en", ifc.fifo_rd_en, 0);
    end
    check("rst_no_pop", popped_n, 0);

    // Single byte A5: one pop, start bit two edges after the sampling edge.
    rd0 = rd_pulses;
    busy0 = busy_cycles;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rd_en_after_release", ifc.fifo_rd_en, 1);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (serial_out === 1'b0) begin
        lat = n;
        break;
      end
    end
    check("start_latency", lat, 2);
    wait_frames(1, "frame_a5_done");
    repeat (20) @(negedge clk);
    #1;
    check("a5_rd_pulses", rd_pulses - rd0, 1);
    check("a5_busy_cycles", busy_cycles - busy0, FrameCycles + 1);
    check("a5_idle_line", serial_out, 1);
    check("a5_idle_busy", busy, 0);

    // Back-to-back 00, FF.
    rd0 = rd_pulses;
    @(posedge clk);
    #1;
    mem[1] = 8'h00;
    mem[2] = 8'hFF;
    pushed_n = 3;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    wait_frames(3, "b2b_done");
    check("b2b_gap", last_gap, 2);
    repeat (20) @(negedge clk);
    #1;
    check("b2b_rd_pulses", rd_pulses - rd0, 2);

    // Empty FIFO for 200 cycles.
    rd0 = rd_pulses;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      #1;
      if (serial_out !== 1'b1) lows++;
    end
    check("empty_line_low", lows, 0);
    check("empty_rd_pulses", rd_pulses - rd0, 0);

    // Reset during data bit 3 of 3C (bit value 1); the byte is lost.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    mem[3] = 8'h3C;
    pushed_n = 4;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (serial_out === 1'b0) break;
    end
    check("mf_start_bit", serial_out, 0);
    repeat (4 * SymT + 4) @(negedge clk);
    check("mf_bit3", serial_out, 1);
    check("mf_busy_before", busy, 1);
    #1;
    rst = 1'b0;
    #1;
    check("mf_async_serial", serial_out, 1);
    check("mf_async_busy", busy, 0);
    check("mf_async_rd_en", ifc.fifo_rd_en, 0);
    @(negedge clk);
    rst = 1'b1;
    rd0 = rd_pulses;
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (serial_out !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("mf_after_idle", lows, 0);
    check("mf_after_rd_pulses", rd_pulses - rd0, 0);
    mon_en = 1'b1;

    // Byte 07: odd number of ones, so the parity bit (when present) is 1.
    busy0 = busy_cycles;
    @(posedge clk);
    #1;
    mem[4] = 8'h07;
    pushed_n = 5;
    exp_q.push_back(8'h07);
    wait_frames(4, "frame_07_done");
    repeat (10) @(negedge clk);
    #1;
    check("f07_busy_cycles", busy_cycles - busy0, FrameCycles + 1);

    check("exp_q_drained", exp_q.size(), 0);
    check("rd_while_empty", rd_while_empty, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
